// File: rtl/axi4_aw_qos_arbiter.sv
// AXI4 write-address channel arbiter: N masters to one slave port.
// Winner priority: starved requesters, then highest awqos (when QoS is
// active), then plain round-robin. One transfer every two cycles at most.
module axi4_aw_qos_arbiter #(
  parameter int unsigned NO_OF_MASTERS = 4,   // 2..16
  parameter int unsigned PAYLOAD_WIDTH = 96,
  parameter int unsigned STARVE_LIMIT  = 8    // 1..15
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  input  logic [1:0]                             qos_mode,
  input  logic [NO_OF_MASTERS-1:0]               m_awvalid,
  output logic [NO_OF_MASTERS-1:0]               m_awready,
  input  logic [4*NO_OF_MASTERS-1:0]             m_awqos,
  input  logic [PAYLOAD_WIDTH*NO_OF_MASTERS-1:0] m_awpayload,
  output logic                                   s_awvalid,
  input  logic                                   s_awready,
  output logic [PAYLOAD_WIDTH-1:0]               s_awpayload,
  output logic [3:0]                             grant_idx
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  typedef enum logic [1:0] {
    QOS_MODE_DISABLE           = 2'b00,
    ONLY_READ_QOS_MODE_ENABLE  = 2'b01,
    WRITE_READ_QOS_MODE_ENABLE = 2'b10,
    ONLY_WRITE_QOS_MODE_ENABLE = 2'b11
  } qos_mode_e;

  localparam logic [3:0] STARVE_CNT = 4'(STARVE_LIMIT);
  localparam logic [3:0] LAST_IDX   = 4'(NO_OF_MASTERS - 1);

  state_e                   state_q, state_d;
  logic [3:0]               grant_q;
  logic [3:0]               rr_ptr_q;
  logic [3:0]               wait_cnt_q [NO_OF_MASTERS];

  logic                     qos_active;
  logic                     handshake;
  logic [3:0]               max_qos;
  logic [NO_OF_MASTERS-1:0] starved;
  logic [NO_OF_MASTERS-1:0] cand;
  logic [3:0]               winner;
  int unsigned              best_dist;

  assign qos_active = (qos_mode == WRITE_READ_QOS_MODE_ENABLE) ||
                      (qos_mode == ONLY_WRITE_QOS_MODE_ENABLE);
  assign handshake  = (state_q == GRANT) && s_awready;
  assign grant_idx  = grant_q;

  // Winner selection: build candidate mask, then pick nearest to rr_ptr.
  // The rotating search is expressed as minimum wrap-distance from rr_ptr,
  // which picks the same index as scanning rr_ptr, rr_ptr+1, ... in order.
  always_comb begin
    max_qos   = '0;
    starved   = '0;
    cand      = m_awvalid;
    winner    = '0;
    best_dist = NO_OF_MASTERS;
    for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
      if (m_awvalid[i] && (m_awqos[4*i +: 4] > max_qos))
        max_qos = m_awqos[4*i +: 4];
      starved[i] = qos_active && m_awvalid[i] && (wait_cnt_q[i] == STARVE_CNT);
    end
    if (|starved) begin
      cand = starved;
    end else if (qos_active) begin
      for (int unsigned i = 0; i < NO_OF_MASTERS; i++)
        cand[i] = m_awvalid[i] && (m_awqos[4*i +: 4] == max_qos);
    end
    for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
      if (cand[i] &&
          (((i + NO_OF_MASTERS - int'(rr_ptr_q)) % NO_OF_MASTERS) < best_dist)) begin
        best_dist = (i + NO_OF_MASTERS - int'(rr_ptr_q)) % NO_OF_MASTERS;
        winner    = 4'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|m_awvalid) state_d = GRANT;
      GRANT:   if (s_awready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: granted master's payload and ready routing.
  always_comb begin
    s_awvalid   = (state_q == GRANT);
    m_awready   = '0;
    s_awpayload = '0;
    for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
      if (grant_q == 4'(i)) begin
        s_awpayload = m_awpayload[PAYLOAD_WIDTH*i +: PAYLOAD_WIDTH];
        if (state_q == GRANT) m_awready[i] = s_awready;
      end
    end
  end

  // Grant capture in IDLE, round-robin pointer advance on handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      if ((state_q == IDLE) && (|m_awvalid))
        grant_q <= winner;
      if (handshake)
        rr_ptr_q <= (grant_q == LAST_IDX) ? '0 : grant_q + 4'd1;
    end
  end

  // Per-master wait counters, only meaningful while QoS is active.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NO_OF_MASTERS; i++) wait_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
        if (!qos_active) begin
          wait_cnt_q[i] <= '0;
        end else if (handshake) begin
          if ((grant_q == 4'(i)) || !m_awvalid[i])
            wait_cnt_q[i] <= '0;
          else if (wait_cnt_q[i] < STARVE_CNT)
            wait_cnt_q[i] <= wait_cnt_q[i] + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_aw_qos_arbiter.sv
// Self-checking bench for axi4_aw_qos_arbiter: vector table, directed
// multi-cycle sequences and randomized traffic against a transaction model.
module tb_axi4_aw_qos_arbiter;

  localparam int N  = 4;
  localparam int PW = 96;
  localparam int SL = 8;

  logic            aclk;
  logic            aresetn;
  logic [1:0]      qos_mode;
  logic [N-1:0]    m_awvalid;
  logic [N-1:0]    m_awready;
  logic [4*N-1:0]  m_awqos;
  logic [PW*N-1:0] m_awpayload;
  logic            s_awvalid;
  logic            s_awready;
  logic [PW-1:0]   s_awpayload;
  logic [3:0]      grant_idx;

  axi4_aw_qos_arbiter #(
    .NO_OF_MASTERS(N),
    .PAYLOAD_WIDTH(PW),
    .STARVE_LIMIT (SL)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .qos_mode   (qos_mode),
    .m_awvalid  (m_awvalid),
    .m_awready  (m_awready),
    .m_awqos    (m_awqos),
    .m_awpayload(m_awpayload),
    .s_awvalid  (s_awvalid),
    .s_awready  (s_awready),
    .s_awpayload(s_awpayload),
    .grant_idx  (grant_idx)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level reference state.
  bit mdl_busy;
  int mdl_gidx;
  int mdl_rr;
  int mdl_wait [N];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    mdl_busy = 1'b0;
    mdl_gidx = 0;
    mdl_rr   = 0;
    for (int i = 0; i < N; i++) mdl_wait[i] = 0;
  endtask

  // Rotating scan from rr over the eligible set chosen by the priority rules.
  function automatic int pick();
    bit act = (qos_mode == 2'b10) || (qos_mode == 2'b11);
    bit any_st = 1'b0;
    int maxq = -1;
    int idx;
    bit elig;
    for (int i = 0; i < N; i++) begin
      if (act && m_awvalid[i] && mdl_wait[i] == SL) any_st = 1'b1;
      if (m_awvalid[i] && int'(m_awqos[4*i +: 4]) > maxq) maxq = int'(m_awqos[4*i +: 4]);
    end
    for (int k = 0; k < N; k++) begin
      idx = (mdl_rr + k) % N;
      if (any_st)   elig = m_awvalid[idx] && (mdl_wait[idx] == SL);
      else if (act) elig = m_awvalid[idx] && (int'(m_awqos[4*idx +: 4]) == maxq);
      else          elig = m_awvalid[idx];
      if (elig) return idx;
    end
    return 0;
  endfunction

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_step();
    bit act = (qos_mode == 2'b10) || (qos_mode == 2'b11);
    if (!aresetn) begin
      model_reset();
    end else if (!mdl_busy) begin
      if (m_awvalid != '0) begin
        mdl_gidx = pick();
        mdl_busy = 1'b1;
      end
      if (!act) for (int i = 0; i < N; i++) mdl_wait[i] = 0;
    end else if (s_awready) begin
      for (int i = 0; i < N; i++) begin
        if (!act || i == mdl_gidx || !m_awvalid[i]) mdl_wait[i] = 0;
        else if (mdl_wait[i] < SL) mdl_wait[i] = mdl_wait[i] + 1;
      end
      mdl_rr   = (mdl_gidx + 1) % N;
      mdl_busy = 1'b0;
    end else if (!act) begin
      for (int i = 0; i < N; i++) mdl_wait[i] = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic model_chk(input string nm);
    logic [N-1:0] er;
    er = '0;
    if (mdl_busy) er[mdl_gidx] = s_awready;
    chk({nm, "_s_awvalid"}, s_awvalid, mdl_busy);
    chk({nm, "_m_awready"}, m_awready, er);
    if (mdl_busy) begin
      chk({nm, "_grant_idx"}, grant_idx, mdl_gidx);
      chk({nm, "_payload"}, s_awpayload, m_awpayload[mdl_gidx*PW +: PW]);
    end
  endtask

  task automatic rand_payload();
    for (int k = 0; k < (PW*N)/32; k++) m_awpayload[k*32 +: 32] = $urandom();
  endtask

  task automatic do_reset();
    aresetn   = 1'b0;
    m_awvalid = '0;
    s_awready = 1'b0;
    qos_mode  = 2'b00;
    m_awqos   = '0;
    model_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
  endtask

  // One arbitration followed by an immediate accept (s_awready=1).
  task automatic arb_accept(input string nm, input int g);
    tick();
    chk({nm, "_valid"}, s_awvalid, 1'b1);
    chk({nm, "_idx"}, grant_idx, g);
    model_chk(nm);
    tick();
    chk({nm, "_done"}, s_awvalid, 1'b0);
  endtask

  typedef struct {
    logic [1:0]   mode;
    logic [N-1:0] valid;
    logic [4*N-1:0] qos;
    int           exp_g;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b00, 4'b1111, 16'h0000, 0};
    vecs[1] = '{2'b00, 4'b0100, 16'h0000, 2};
    vecs[2] = '{2'b11, 4'b1010, 16'h9020, 3};
    vecs[3] = '{2'b00, 4'b1010, 16'h9020, 1};
    vecs[4] = '{2'b10, 4'b1111, 16'h0992, 1};
    vecs[5] = '{2'b01, 4'b1111, 16'h0992, 0};
    vecs[6] = '{2'b11, 4'b1100, 16'h5500, 2};
    vecs[7] = '{2'b11, 4'b1000, 16'hF000, 3};

    m_awpayload = '0;
    rand_payload();
    aresetn   = 1'b0;
    m_awvalid = '0;
    s_awready = 1'b0;
    qos_mode  = 2'b00;
    m_awqos   = '0;
    model_reset();
    #12;
    chk("reset_s_awvalid", s_awvalid, 1'b0);
    chk("reset_m_awready", m_awready, 4'b0000);
    chk("reset_grant_idx", grant_idx, 4'd0);
    do_reset();
    tick();
    chk("idle_no_request", s_awvalid, 1'b0);

    // Vector table: single arbitration from a fresh reset.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      qos_mode  = vecs[v].mode;
      m_awvalid = vecs[v].valid;
      m_awqos   = vecs[v].qos;
      s_awready = 1'b1;
      #1;
      chk($sformatf("vec%0d_pre", v), s_awvalid, 1'b0);
      tick();
      chk($sformatf("vec%0d_valid", v), s_awvalid, 1'b1);
      chk($sformatf("vec%0d_grant", v), grant_idx, vecs[v].exp_g);
      model_chk($sformatf("vec%0d", v));
    end

    // QoS ordering, one transaction per master: 1, 2, then 0.
    do_reset();
    qos_mode = 2'b11; m_awqos = 16'h0992; m_awvalid = 4'b0111; s_awready = 1'b1;
    arb_accept("qos_first", 1);
    m_awvalid[1] = 1'b0;
    arb_accept("qos_second", 2);
    m_awvalid[2] = 1'b0;
    arb_accept("qos_third", 0);

    // Plain round-robin with all masters requesting.
    do_reset();
    m_awvalid = 4'b1111; s_awready = 1'b1;
    for (int k = 0; k < 5; k++) arb_accept($sformatf("rr%0d", k), k % N);

    // Starvation: m3 wins the 9th arbitration, then m0 resumes.
    do_reset();
    qos_mode = 2'b11; m_awqos = 16'h000F; m_awvalid = 4'b1001; s_awready = 1'b1;
    for (int k = 0; k < SL; k++) arb_accept($sformatf("starve_m0_%0d", k), 0);
    arb_accept("starve_m3", 3);
    arb_accept("starve_resume", 0);

    // Backpressure: hold m2 for 5 cycles, handshake on the 6th.
    do_reset();
    m_awvalid = 4'b0100; s_awready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), s_awvalid, 1'b1);
      chk($sformatf("bp%0d_idx", c), grant_idx, 4'd2);
      chk($sformatf("bp%0d_payload", c), s_awpayload, m_awpayload[2*PW +: PW]);
      chk($sformatf("bp%0d_ready", c), m_awready, 4'b0000);
      tick();
    end
    s_awready = 1'b1;
    #1;
    chk("bp_accept_ready", m_awready, 4'b0100);
    chk("bp_accept_valid", s_awvalid, 1'b1);
    tick();
    chk("bp_done", s_awvalid, 1'b0);

    // Reset in the middle of a grant, after rr_ptr has moved.
    do_reset();
    m_awvalid = 4'b1111; s_awready = 1'b1;
    arb_accept("rst_pre", 0);
    s_awready = 1'b0;
    tick();
    chk("rst_grant_m1", grant_idx, 4'd1);
    aresetn = 1'b0;
    #1;
    chk("rst_async_valid", s_awvalid, 1'b0);
    chk("rst_async_ready", m_awready, 4'b0000);
    chk("rst_async_idx", grant_idx, 4'd0);
    model_reset();
    tick();
    aresetn = 1'b1;
    s_awready = 1'b1;
    #1;
    tick();
    chk("rst_restart_idx", grant_idx, 4'd0);
    model_chk("rst_restart");

    // Randomized traffic against the reference model.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      aresetn = ($urandom_range(0, 199) != 0);
      qos_mode = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        m_awvalid[i] = ($urandom_range(0, 3) != 0);
        m_awqos[4*i +: 4] = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      end
      s_awready = ($urandom_range(0, 3) != 0);
      rand_payload();
      if (!aresetn) model_reset();
      #1;
      model_chk("rand");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
